uart_rx_deserializer: RTL and testbench

//  Receive end of the UART link. Oversamples the asynchronous serial line, frames start/data/stop bits
//  (LSB first) and presents each character on a valid/ready output holding register.

---
 rtl/uart_globals_pkg.sv | 16 +
 rtl/uart_baud_tick_gen.sv | 36 +++
 rtl/uart_rx_deserializer.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_globals_pkg.sv
// Constants and types shared by the transmit and receive ends of the UART link.
// The receive FSM state type lives here so both ends and benches agree on it.
package uart_globals_pkg;

  parameter int CHAR_LENGTH = 8;
  parameter int OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Programmable sample-tick divider: counts 0..i_div and pulses o_tick on the terminal count.
// Shared by both link ends; i_clr forces the phase back to zero.
module uart_baud_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_terminal;

  assign w_terminal = (r_cnt == i_div);
  assign o_tick     = i_en && !i_clr && w_terminal;

  // NOTE: clocked state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_terminal) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive end: synchronizes the serial line, frames start/data/stop bits (LSB first)
// and holds each character on a valid/ready register. Define UART_RX_PARITY_EN for a parity bit.
module uart_rx_deserializer #(
  parameter int CHAR_LENGTH = uart_globals_pkg::CHAR_LENGTH,
  parameter int OVERSAMPLE  = uart_globals_pkg::OVERSAMPLE,
  parameter int DIV_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic                   rx_serial,
  output logic [CHAR_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   framing_err,
`ifdef UART_RX_PARITY_EN
  output logic                   overrun_err,
  input  logic                   parity_odd,
  output logic                   parity_err
`else
  output logic                   overrun_err
`endif
);

  import uart_globals_pkg::*;

  localparam int TICK_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(CHAR_LENGTH + 1);
  localparam int HALF_BIT = OVERSAMPLE / 2;

  // Line synchronizer and edge detector; all three flops idle high.
  logic r_sync_meta;
  logic r_sync;
  logic r_sync_prev;
  logic w_start_edge;

  uart_rx_state_e r_state;
  uart_rx_state_e w_state_next;

  logic [DIV_W-1:0]       r_baud_div_q;
  logic                   w_tick;
  logic [TICK_W-1:0]      r_tick_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [CHAR_LENGTH-1:0] r_shift;
  logic                   w_sample_pt;
  logic                   w_shift_en;
  logic                   w_complete;
  logic                   w_load;
  logic                   w_parity_bad;

  logic [CHAR_LENGTH-1:0] r_rx_data;
  logic                   r_rx_valid;
  logic                   r_framing_err;
  logic                   r_overrun_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync_meta <= rx_serial;
      r_sync      <= r_sync_meta;
      r_sync_prev <= r_sync;
    end
  end

  assign w_start_edge = r_sync_prev && !r_sync;

  // Divider phase is pinned to zero while idle so tick timing is relative to the start edge.
  uart_baud_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state != RX_IDLE),
    .i_clr  (r_state == RX_IDLE),
    .i_div  (r_baud_div_q),
    .o_tick (w_tick)
  );

  // Mid-start-bit sample after half a bit, then one sample every full bit.
  assign w_sample_pt = w_tick &&
                       ((r_state == RX_START) ? (r_tick_cnt == TICK_W'(HALF_BIT - 1))
                                              : (r_tick_cnt == TICK_W'(OVERSAMPLE - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal written here gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_complete   = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (w_start_edge) begin
          w_state_next = RX_START;
        end
      end
      RX_START: begin
        if (w_sample_pt) begin
          w_state_next = r_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_sample_pt) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_W'(CHAR_LENGTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = RX_PARITY;
`else
            w_state_next = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (w_sample_pt) begin
          w_state_next = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_sample_pt) begin
          w_complete   = 1'b1;
          w_state_next = RX_IDLE;
        end
      end
      default: begin
        w_state_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_div_q <= '0;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
    end else begin
      if (r_state == RX_IDLE && w_start_edge) begin
        r_baud_div_q <= baud_div;
      end

      if (r_state == RX_IDLE || w_sample_pt) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

      if (r_state != RX_DATA) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      // Shifting in from the top leaves the first (LSB) bit at index 0 after the last shift.
      if (w_shift_en) begin
        r_shift <= {r_sync, r_shift[CHAR_LENGTH-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_bit <= 1'b0;
    end else if (r_state == RX_PARITY && w_sample_pt) begin
      r_par_bit <= r_sync;
    end
  end

  assign w_parity_bad = ((^r_shift) ^ r_par_bit) != parity_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_complete && w_parity_bad;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign w_parity_bad = 1'b0;
`endif

  // A good stop bit loads the holding register if it is empty or being drained this cycle.
  assign w_load = w_complete && r_sync && (!r_rx_valid || rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_framing_err <= w_complete && !r_sync;
      r_overrun_err <= w_complete && r_sync && r_rx_valid && !rx_ready;
      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign framing_err = r_framing_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frame-level reference model plus directed scenarios.
// Builds with or without UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  import uart_globals_pkg::*;

  localparam int CL    = CHAR_LENGTH;
  localparam int OS    = OVERSAMPLE;
  localparam int DIV_W = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] baud_div;
  logic             rx_serial;
  logic [CL-1:0]    rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             framing_err;
  logic             overrun_err;
  logic             parity_err;
`ifdef UART_RX_PARITY_EN
  logic             parity_odd;
`endif

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .CHAR_LENGTH (CL),
    .OVERSAMPLE  (OS),
    .DIV_W       (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
`ifdef UART_RX_PARITY_EN
    .overrun_err (overrun_err),
    .parity_odd  (parity_odd),
    .parity_err  (parity_err)
`else
    .overrun_err (overrun_err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: each frame sent is a record that resolves on a known clock.
  typedef struct {
    int            done;
    logic [CL-1:0] data;
    bit            stop_ok;
    bit            par_bad;
  } frame_t;

  frame_t        pend[$];
  int            cyc = 0;
  bit            m_valid = 1'b0;
  logic [CL-1:0] m_data = '0;
  bit            m_ferr = 1'b0;
  bit            m_oerr = 1'b0;
  bit            m_perr = 1'b0;

  // Start edge driven after clock k resolves on clock k + latency: two synchronizer clocks,
  // one edge-detect clock, then half a start bit plus the remaining bits at OS ticks each,
  // one tick every div+1 clocks.
  function automatic int frame_latency(input int div);
    return 3 + (OS / 2 + OS * (CL + 1 + PBITS)) * (div + 1);
  endfunction

  initial begin
    frame_t f;
    bit     load;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
        m_perr  = 1'b0;
        pend.delete();
      end else begin
        m_ferr = 1'b0;
        m_oerr = 1'b0;
        m_perr = 1'b0;
        load   = 1'b0;
        if (pend.size() > 0 && pend[0].done == cyc) begin
          f      = pend.pop_front();
          m_perr = f.par_bad;
          if (!f.stop_ok)                 m_ferr = 1'b1;
          else if (!m_valid || rx_ready)  load   = 1'b1;
          else                            m_oerr = 1'b1;
        end
        if (load) begin
          m_valid = 1'b1;
          m_data  = f.data;
        end else if (m_valid && rx_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare process and DUT event counters.
  int n_rise = 0, n_vcyc = 0, n_ferr = 0, n_oerr = 0, n_perr = 0;
  int last_rise = 0;
  bit prev_valid = 1'b0;

  initial begin
    logic [31:0] act;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      act = 32'({rx_valid, framing_err, overrun_err, parity_err, rx_data});
      if (rst) begin
        check("reset_outputs", act, 32'd0);
      end else begin
        exp = 32'({m_valid, m_ferr, m_oerr, m_perr, m_data});
        check("cycle_outputs", act, exp);
      end
      if (rx_valid && !prev_valid) begin
        n_rise++;
        last_rise = cyc;
      end
      prev_valid = rx_valid;
      n_vcyc += int'(rx_valid);
      n_ferr += int'(framing_err);
      n_oerr += int'(overrun_err);
      n_perr += int'(parity_err);
    end
  end

  // Single driver of rx_ready: directed value or random per clock.
  bit ready_cmd  = 1'b1;
  bit rand_ready = 1'b0;

  initial begin
    rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  int last_start = 0;

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [CL-1:0] data, input bit stop_bit, input bit par_bad,
                            input int div, input int abort_bits, input bit scramble_div);
    bit     seq[$];
    int     len;
    int     n;
    frame_t f;
    len      = OS * (div + 1);
    n        = 0;
    baud_div = DIV_W'(div);
    seq.push_back(1'b0);
    for (int i = 0; i < CL; i++) seq.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
    seq.push_back((^data) ^ parity_odd ^ par_bad);
`endif
    seq.push_back(stop_bit);
    @(posedge clk);
    #1;
    last_start = cyc;
    if (abort_bits == 0) begin
      f.done    = cyc + frame_latency(div);
      f.data    = data;
      f.stop_ok = stop_bit;
      f.par_bad = (PBITS != 0) && par_bad;
      pend.push_back(f);
    end
    for (int i = 0; i < seq.size(); i++) begin
      if (abort_bits != 0 && i == abort_bits) return;
      rx_serial = seq[i];
      repeat (len) begin
        @(posedge clk);
        #1;
        n++;
        if (scramble_div && n == 6) baud_div = DIV_W'($urandom_range(0, 7));
      end
    end
  endtask

  int v0, r0, f0, o0, p0;

  task automatic snap();
    v0 = n_vcyc;
    r0 = n_rise;
    f0 = n_ferr;
    o0 = n_oerr;
    p0 = n_perr;
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    rx_serial = 1'b1;
    baud_div  = '0;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_flags", 32'({framing_err, overrun_err, parity_err}), 32'd0);
    rst = 1'b0;
    idle(5);

    // Clean 0xA5.
    snap();
    send_frame(CL'('hA5), 1'b1, 1'b0, 0, 0, 1'b0);
    idle(20);
    check("t1_valid_cycles", 32'(n_vcyc - v0), 32'd1);
    check("t1_data", 32'(rx_data), 32'hA5);
    check("t1_model_data", 32'(m_data), 32'hA5);
    check("t1_no_flags", 32'(n_ferr + n_oerr + n_perr - f0 - o0 - p0), 32'd0);
    check("t1_latency_ok", 32'((last_rise - last_start) >= 1 && (last_rise - last_start) <= 155), 32'd1);

    // 6-clock low glitch.
    snap();
    baud_div = '0;
    rx_serial = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    idle(200);
    check("t2_no_valid", 32'(n_rise - r0), 32'd0);
    check("t2_no_ferr", 32'(n_ferr - f0), 32'd0);

    // Bad stop bit, line held low, then a clean 0x11.
    snap();
    send_frame(CL'('h3C), 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    check("t3_ferr_pulse", 32'(n_ferr - f0), 32'd1);
    check("t3_no_valid", 32'(n_vcyc - v0), 32'd0);
    idle(40);
    send_frame(CL'('h11), 1'b1, 1'b0, 0, 0, 1'b0);
    idle(20);
    check("t3_data_11", 32'(rx_data), 32'h11);
    check("t3_one_char", 32'(n_rise - r0), 32'd1);

    // Overrun with consumer stalled.
    snap();
    ready_cmd = 1'b0;
    send_frame(CL'('h01), 1'b1, 1'b0, 0, 0, 1'b0);
    idle(10);
    send_frame(CL'('h02), 1'b1, 1'b0, 0, 0, 1'b0);
    idle(10);
    check("t4_held_data", 32'(rx_data), 32'h01);
    check("t4_held_valid", 32'(rx_valid), 32'd1);
    check("t4_overrun", 32'(n_oerr - o0), 32'd1);
    ready_cmd = 1'b1;
    idle(3);
    check("t4_drained", 32'(rx_valid), 32'd0);

    // Ready pulsed on the completing clock of the second character.
    snap();
    ready_cmd = 1'b0;
    send_frame(CL'('h01), 1'b1, 1'b0, 0, 0, 1'b0);
    idle(10);
    fork
      send_frame(CL'('h02), 1'b1, 1'b0, 0, 0, 1'b0);
      begin
        @(posedge clk);
        #3;
        k = cyc;
        while (cyc != k + frame_latency(0) - 1) begin
          @(posedge clk);
          #1;
        end
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
      end
    join
    idle(10);
    check("t5_no_overrun", 32'(n_oerr - o0), 32'd0);
    check("t5_data_02", 32'(rx_data), 32'h02);
    check("t5_valid_kept", 32'(rx_valid), 32'd1);
    ready_cmd = 1'b1;
    idle(3);

    // Reset in the middle of the data bits of 0x7E.
    send_frame(CL'('h7E), 1'b1, 1'b0, 0, 4, 1'b0);
    rx_serial = 1'b1;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(rx_valid), 32'd0);
    check("t6_rst_data", 32'(rx_data), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(30);
    snap();
    send_frame(CL'('h55), 1'b1, 1'b0, 0, 0, 1'b0);
    idle(20);
    check("t6_data_55", 32'(rx_data), 32'h55);
    check("t6_one_char", 32'(n_rise - r0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // Even parity expected, parity bit wrong: flagged but delivered.
    snap();
    parity_odd = 1'b0;
    send_frame(CL'('h07), 1'b1, 1'b1, 0, 0, 1'b0);
    idle(20);
    check("t7_parity_err", 32'(n_perr - p0), 32'd1);
    check("t7_data_07", 32'(rx_data), 32'h07);
`endif

    // Randomized frames, divisors, stop bits and consumer back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'($urandom_range(0, 1));
`endif
      send_frame(CL'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2), 0, 1'b1);
      idle($urandom_range(2, 30));
    end
    rand_ready = 1'b0;
    ready_cmd  = 1'b1;
    idle(50);
    check("rand_all_resolved", 32'(pend.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
